// File: rtl/d_fifo_drain_arbiter_if.sv
// d_fifo_drain_arbiter_if: FIFO drain side, delivery handshake and counters
interface d_fifo_drain_arbiter_if #(
  parameter int DATA_WIDTH  = 6,
  parameter int COUNT_WIDTH = 8
);
  logic                   enable;
  logic                   empty_fifo_D0;
  logic                   empty_fifo_D1;
  logic [DATA_WIDTH-1:0]  data_out_D0;
  logic [DATA_WIDTH-1:0]  data_out_D1;
  logic                   D0_pop;
  logic                   D1_pop;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   dest_out;
  logic                   valid_out;
  logic                   ready_in;
  logic [COUNT_WIDTH-1:0] count_D0;
  logic [COUNT_WIDTH-1:0] count_D1;
  logic                   busy;
  modport master (
    input  enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, ready_in,
    output D0_pop, D1_pop, data_out, dest_out, valid_out, count_D0, count_D1, busy
  );
  modport slave (
    output enable, empty_fifo_D0, empty_fifo_D1, data_out_D0, data_out_D1, ready_in,
    input  D0_pop, D1_pop, data_out, dest_out, valid_out, count_D0, count_D1, busy
  );
endinterface

// File: rtl/d_fifo_drain_arbiter.sv
// d_fifo_drain_arbiter: round-robin drain of FIFOs D0/D1 into one valid/ready port
module d_fifo_drain_arbiter #(
  parameter int DATA_WIDTH  = 6,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  d_fifo_drain_arbiter_if.master    bus
);
  typedef enum logic [1:0] {IDLE, POP, CAP, SEND} state_t;
  state_t                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   last_q, last_d;
  logic                   pop0_q, pop0_d;
  logic                   pop1_q, pop1_d;
  logic                   dest_q, dest_d;
  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [COUNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [COUNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic                   both, go, pick;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      dest_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      pop0_q  <= pop0_d;
      pop1_q  <= pop1_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  // With both FIFOs non-empty the channel not served last wins; otherwise the non-empty one
  always_comb begin
    both    = ~bus.empty_fifo_D0 & ~bus.empty_fifo_D1;
    go      = bus.enable & ~(bus.empty_fifo_D0 & bus.empty_fifo_D1);
    pick    = both ? ~last_q : bus.empty_fifo_D0;
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        state_d = go ? POP : IDLE;
        sel_d   = go ? pick : sel_q;
      end
      POP: state_d = CAP;
      CAP: begin
        state_d = SEND;
        data_d  = sel_q ? bus.data_out_D1 : bus.data_out_D0;
        dest_d  = sel_q;
        valid_d = 1'b1;
        last_d  = sel_q;
        cnt0_d  = cnt0_q + COUNT_WIDTH'(!sel_q);
        cnt1_d  = cnt1_q + COUNT_WIDTH'(sel_q);
      end
      SEND: if (bus.ready_in) begin
        valid_d = 1'b0;
        state_d = go ? POP : IDLE;
        sel_d   = go ? pick : sel_q;
      end
      default: state_d = IDLE;
    endcase
    pop0_d = (state_d == POP) & ~sel_d;
    pop1_d = (state_d == POP) & sel_d;
  end
  always_comb begin
    bus.D0_pop    = pop0_q;
    bus.D1_pop    = pop1_q;
    bus.data_out  = data_q;
    bus.dest_out  = dest_q;
    bus.valid_out = valid_q;
    bus.count_D0  = cnt0_q;
    bus.count_D1  = cnt1_q;
    bus.busy      = state_q != IDLE;
  end
endmodule

// File: doc/d_fifo_drain_arbiter.md
Name: d_fifo_drain_arbiter

Overview:
- Downstream consumer of the full-logic transmission block's destination FIFOs D0 and D1.
- Watches their empty flags and issues single-cycle pops using round-robin.
- Captures each popped word and presents it on one output port with a valid/ready handshake, tagged with its source channel.
- Keeps per-channel delivered-word counters for link statistics.

Parameters:
- DATA_WIDTH, 6, width of FIFO words and of data_out.
- COUNT_WIDTH, 8, width of each delivered-word counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  when high the block may start new pops.
- empty_fifo_D0  in  1  D0 FIFO empty flag.
- empty_fifo_D1  in  1  D1 FIFO empty flag.
- data_out_D0  in  DATA_WIDTH  D0 FIFO read data; valid in the cycle after the cycle in which D0_pop was high.
- data_out_D1  in  DATA_WIDTH  D1 FIFO read data; same timing as D0.
- D0_pop  out  1  registered pop strobe to D0 FIFO.
- D1_pop  out  1  registered pop strobe to D1 FIFO.
- data_out  out  DATA_WIDTH  delivered word.
- dest_out  out  1  source of data_out: 0=D0, 1=D1.
- valid_out  out  1  data_out/dest_out valid.
- ready_in  in  1  downstream accepts the word when valid_out & ready_in at a rising edge.
- count_D0  out  COUNT_WIDTH  words delivered from D0.
- count_D1  out  COUNT_WIDTH  words delivered from D1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE; last_served=1, so D0 wins the first tie.

FSM states, all outputs registered:
- IDLE: at each edge, if enable and at least one empty flag is low:
  - pick a channel;
  - set that channel's pop to 1;
  - go to POP.
  - Otherwise stay in IDLE.
- POP: the selected pop is high for exactly this one cycle. Next edge: pop to 0, go to CAP.
- CAP: the selected FIFO's data is valid this cycle. Next edge:
  - data_out and dest_out are loaded;
  - valid_out goes to 1;
  - that channel's counter increments;
  - last_served is updated to that channel;
  - go to SEND.
- SEND: valid_out held; data_out and dest_out must stay stable until handshake. On the handshake edge:
  - if enable and a channel is non-empty: valid_out to 0, the next pick's pop to 1, go to POP (back-to-back);
  - else: valid_out to 0, go to IDLE.

Arbitration:
- Both non-empty: pick the channel != last_served.
- Exactly one non-empty: pick it.
- Empty flags are sampled only at the decision edge.

Pop and underflow rules:
- At most one pop is high in any cycle.
- Never two pops in consecutive cycles.
- Max throughput is one word per 3 cycles.
- A pop is only issued when the flag sampled at that edge is 0, so no underflow is possible.

Counters:
- Wrap modulo 2^COUNT_WIDTH; 255+1 -> 0.
- Increment only in the CAP->SEND transition.

Enable:
- enable low mid-word: the current word completes through SEND.
- No new pop is issued while enable is low.

Backpressure:
- ready_in low holds SEND indefinitely with no extra pops.

Reset:
- Reset asserted in any state: pops drop immediately (asynchronously) and any word in flight is discarded.
- Counters and FSM return to reset values.

Test Plan:
- Reset then enable=1, both FIFOs empty, ready_in=1 -> D0_pop and D1_pop stay 0, busy=0, valid_out=0 for 10 cycles.
- D0 holds 6'b000101, D1 empty, ready_in=1 -> D0_pop high 1 cycle; 2 cycles later valid_out=1, data_out=6'b000101, dest_out=0; count_D0=1.
- Both FIFOs non-empty, D0 words 6'b000100, 6'b000110 and D1 words 6'b100010, 6'b100011, ready_in=1:
  - delivery order is D0,D1,D0,D1;
  - valid_out pulses are 3 cycles apart;
  - final count_D0=2, count_D1=2.
- D1 word 6'b001110 delivered with ready_in=0 for 5 cycles -> valid_out held, data_out stable, no pops; ready_in=1 -> handshake, then IDLE.
- 256 D0 words, ready_in=1 -> count_D0 wraps to 0; count_D1 stays 0.
- Reset asserted during POP with D1_pop=1 -> D1_pop drops before the next clock edge; after release the FSM is in IDLE and counters are 0.
- enable dropped while in CAP -> the word is still delivered and no further pop occurs.
